// File: rtl/vga_timing_meas.sv
// rtl/vga_timing_meas.sv - video timing measurement and lock detector (optional VIDEO_CRC_EN adds FRAME_CRC)
`timescale 1ns/1ps
module vga_timing_meas #(
    parameter int   CW          = 12,
    parameter logic HS_ACT      = 1'b0,
    parameter logic VS_ACT      = 1'b0,
    parameter int   LOCK_FRAMES = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    VGA_R,
    input  logic [7:0]    VGA_G,
    input  logic [7:0]    VGA_B,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    input  logic          VGA_DE,
    output logic [CW-1:0] H_TOTAL,
    output logic [CW-1:0] H_ACTIVE,
    output logic [CW-1:0] V_TOTAL,
    output logic [CW-1:0] V_ACTIVE,
    output logic          FRAME_DONE,
    output logic          LOCKED,
    output logic          SIG_LOST
`ifdef VIDEO_CRC_EN
    ,
    output logic [15:0]   FRAME_CRC
`endif
);
    localparam logic [CW-1:0] MAX = '1;
    localparam logic [4:0]    LF  = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, COUNT, LOCK} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    logic hs_q, hs_d, vs_q, vs_d, de_q;
    logic hse, vse, meas, lost_now, crc_match;
    logic h_run, v_run, ht_seen, ha_seen, frame_bad;
    logic [CW-1:0] h_cnt, de_cnt, v_cnt, va_cnt, f_ht, f_ha;
    logic [CW-1:0] ref_ht, ref_ha, ref_vt, ref_va;
    logic [CW-1:0] ht_n, ha_n, vc_n, vac_n;
    logic ht_seen_n, ha_seen_n, bad_n, match;
    logic [3:0] stable;
    logic [4:0] stable_inc;
    state_t state;

    // Input stage: registered copy plus one-cycle delayed sync copies; idle at the inactive level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hs_q <= ~HS_ACT;
            hs_d <= ~HS_ACT;
            vs_q <= ~VS_ACT;
            vs_d <= ~VS_ACT;
            de_q <= 1'b0;
        end else begin
            hs_q <= VGA_HS;
            hs_d <= hs_q;
            vs_q <= VGA_VS;
            vs_d <= vs_q;
            de_q <= VGA_DE;
        end
    end

    assign hse      = (hs_q == HS_ACT) && (hs_d != HS_ACT);
    assign vse      = (vs_q == VS_ACT) && (vs_d != VS_ACT);
    assign meas     = hse && h_run;
    assign lost_now = !hse && (h_cnt == MAX);

`ifdef VIDEO_CRC_EN
    function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    logic [23:0] rgb_q;
    logic [15:0] crc_run, ref_crc;

    // Running CRC over active pixels; a pixel in the VSE cycle starts the new frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rgb_q   <= '0;
            crc_run <= 16'hFFFF;
        end else begin
            rgb_q <= {VGA_R, VGA_G, VGA_B};
            if (vse)
                crc_run <= de_q ? crc24(16'hFFFF, rgb_q) : 16'hFFFF;
            else if (de_q)
                crc_run <= crc24(crc_run, rgb_q);
        end
    end

    assign crc_match = (crc_run == ref_crc);
`else
    logic unused_rgb;
    assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
    assign crc_match  = 1'b1;
`endif

    // Frame accumulation including the current cycle's line measurement (so a coincident HSE lands in the ending frame)
    always_comb begin
        ht_n      = f_ht;
        ha_n      = f_ha;
        ht_seen_n = ht_seen;
        ha_seen_n = ha_seen;
        bad_n     = frame_bad;
        vc_n      = v_cnt;
        vac_n     = va_cnt;
        if (hse)
            vc_n = sat_inc(v_cnt);
        if (meas) begin
            if (!ht_seen) begin
                ht_n      = sat_inc(h_cnt);
                ht_seen_n = 1'b1;
            end else if (sat_inc(h_cnt) != f_ht) begin
                bad_n = 1'b1;
            end
            // Active width comes from the first non-blanking line, since frames usually open in blanking
            if (de_cnt != '0) begin
                vac_n = sat_inc(va_cnt);
                if (!ha_seen) begin
                    ha_n      = de_cnt;
                    ha_seen_n = 1'b1;
                end else if (de_cnt != f_ha) begin
                    bad_n = 1'b1;
                end
            end
        end
    end

    assign match = (ht_n == ref_ht) && (ha_n == ref_ha) && (vc_n == ref_vt) &&
                   (vac_n == ref_va) && crc_match;
    assign stable_inc = {1'b0, stable} + 5'd1;

    // Line/frame counters, signal-loss detection, output latching and lock state machine
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt <= '0; de_cnt <= '0; v_cnt <= '0; va_cnt <= '0;
            f_ht <= '0; f_ha <= '0; ht_seen <= 1'b0; ha_seen <= 1'b0; frame_bad <= 1'b0;
            ref_ht <= '0; ref_ha <= '0; ref_vt <= '0; ref_va <= '0;
            h_run <= 1'b0; v_run <= 1'b0; stable <= '0; state <= SEARCH;
            H_TOTAL <= '0; H_ACTIVE <= '0; V_TOTAL <= '0; V_ACTIVE <= '0;
            FRAME_DONE <= 1'b0; LOCKED <= 1'b0; SIG_LOST <= 1'b0;
`ifdef VIDEO_CRC_EN
            ref_crc <= '0; FRAME_CRC <= '0;
`endif
        end else begin
            FRAME_DONE <= 1'b0;
            h_cnt      <= sat_inc(h_cnt);
            if (de_q)
                de_cnt <= sat_inc(de_cnt);
            f_ht <= ht_n; f_ha <= ha_n; ht_seen <= ht_seen_n; ha_seen <= ha_seen_n;
            frame_bad <= bad_n; v_cnt <= vc_n; va_cnt <= vac_n;
            if (hse) begin
                h_cnt    <= '0;
                de_cnt   <= {{(CW-1){1'b0}}, de_q};
                h_run    <= 1'b1;
                SIG_LOST <= 1'b0;
            end else if (lost_now) begin
                SIG_LOST <= 1'b1;
                h_run <= 1'b0; v_run <= 1'b0; stable <= '0; state <= SEARCH; LOCKED <= 1'b0;
                H_TOTAL <= '0; H_ACTIVE <= '0; V_TOTAL <= '0; V_ACTIVE <= '0;
`ifdef VIDEO_CRC_EN
                FRAME_CRC <= '0;
`endif
            end
            if (vse && !lost_now) begin
                v_cnt <= '0; va_cnt <= '0; frame_bad <= 1'b0; ht_seen <= 1'b0; ha_seen <= 1'b0;
                v_run <= 1'b1;
                if (v_run) begin
                    H_TOTAL <= ht_n; H_ACTIVE <= ha_n; V_TOTAL <= vc_n; V_ACTIVE <= vac_n;
                    FRAME_DONE <= 1'b1;
`ifdef VIDEO_CRC_EN
                    FRAME_CRC <= crc_run;
`endif
                    if (state != SEARCH && !bad_n && match) begin
                        if (state == COUNT) begin
                            stable <= stable_inc[3:0];
                            if (stable_inc >= LF) begin
                                state  <= LOCK;
                                LOCKED <= 1'b1;
                            end
                        end
                    end else begin
                        LOCKED <= 1'b0;
                        if (!bad_n) begin
                            ref_ht <= ht_n; ref_ha <= ha_n; ref_vt <= vc_n; ref_va <= vac_n;
`ifdef VIDEO_CRC_EN
                            ref_crc <= crc_run;
`endif
                            stable <= 4'd1;
                            state  <= COUNT;
                        end else begin
                            stable <= '0;
                            state  <= SEARCH;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_meas.sv
// tb/tb_vga_timing_meas.sv - directed bench for vga_timing_meas (scaled-down raster timings)
`timescale 1ns/1ps
module tb_vga_timing_meas;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_l = 1'b0, vs_l = 1'b0, de = 1'b0;
    logic [23:0] rgb = '0;
    logic [11:0] ht0, ha0, vt0, va0, ht1, ha1, vt1, va1;
    logic fd0, lk0, sl0, fd1, lk1, sl1;
    logic [15:0] crc0, crc1;
    int n_tests = 0;
    int n_fail  = 0;
    int fd_n [2];
    logic [11:0] cap_ht [2][64];
    logic [11:0] cap_ha [2][64];
    logic [11:0] cap_vt [2][64];
    logic [11:0] cap_va [2][64];
    logic        cap_lk [2][64];
    logic [15:0] cap_crc [64];
    int n0, n1;
    logic [15:0] crc_exp;

    always #5 clk = ~clk;

    vga_timing_meas #(.CW(12), .HS_ACT(1'b0), .VS_ACT(1'b0), .LOCK_FRAMES(3)) dut0 (
        .CLK(clk), .RST(rst), .VGA_R(rgb[23:16]), .VGA_G(rgb[15:8]), .VGA_B(rgb[7:0]),
        .VGA_HS(~hs_l), .VGA_VS(~vs_l), .VGA_DE(de),
        .H_TOTAL(ht0), .H_ACTIVE(ha0), .V_TOTAL(vt0), .V_ACTIVE(va0),
        .FRAME_DONE(fd0), .LOCKED(lk0), .SIG_LOST(sl0)
`ifdef VIDEO_CRC_EN
        , .FRAME_CRC(crc0)
`endif
    );

    vga_timing_meas #(.CW(12), .HS_ACT(1'b1), .VS_ACT(1'b1), .LOCK_FRAMES(3)) dut1 (
        .CLK(clk), .RST(rst), .VGA_R(rgb[23:16]), .VGA_G(rgb[15:8]), .VGA_B(rgb[7:0]),
        .VGA_HS(hs_l), .VGA_VS(vs_l), .VGA_DE(de),
        .H_TOTAL(ht1), .H_ACTIVE(ha1), .V_TOTAL(vt1), .V_ACTIVE(va1),
        .FRAME_DONE(fd1), .LOCKED(lk1), .SIG_LOST(sl1)
`ifdef VIDEO_CRC_EN
        , .FRAME_CRC(crc1)
`endif
    );

`ifndef VIDEO_CRC_EN
    assign crc0 = '0;
    assign crc1 = '0;
`endif

    always @(negedge clk) begin
        if (fd0 === 1'b1 && fd_n[0] < 64) begin
            cap_ht[0][fd_n[0]] = ht0; cap_ha[0][fd_n[0]] = ha0;
            cap_vt[0][fd_n[0]] = vt0; cap_va[0][fd_n[0]] = va0;
            cap_lk[0][fd_n[0]] = lk0; cap_crc[fd_n[0]] = crc0;
            fd_n[0]++;
        end
        if (fd1 === 1'b1 && fd_n[1] < 64) begin
            cap_ht[1][fd_n[1]] = ht1; cap_ha[1][fd_n[1]] = ha1;
            cap_vt[1][fd_n[1]] = vt1; cap_va[1][fd_n[1]] = va1;
            cap_lk[1][fd_n[1]] = lk1;
            fd_n[1]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // HS at x 0..3, DE at x 6..6+hact-1, VS held for the whole of line 0
    task automatic drive_line(input int htot, input int hact, input bit vsync, input bit act,
                              input bit extra, input bit badpix);
        for (int x = 0; x < htot + int'(extra); x++) begin
            @(negedge clk);
            hs_l = (x < 4);
            vs_l = vsync;
            de   = act && (x >= 6) && (x < 6 + hact);
            rgb  = !de ? 24'h000000 : ((badpix && x == 10) ? 24'h123456 : 24'hFFFFFF);
        end
    endtask

    task automatic send_frame(input int htot, input int hact, input int vact,
                              input int y0, input int y1, input int long_y, input int bad_y);
        for (int y = y0; y < y1; y++)
            drive_line(htot, hact, y == 0, (y >= 2) && (y < 2 + vact), y == long_y, y == bad_y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs_l = 1'b0; vs_l = 1'b0; de = 1'b0; rgb = '0;
        end
    endtask

    function automatic logic [15:0] crc_model(input int npix);
        logic [15:0] c;
        logic [23:0] px;
        c  = 16'hFFFF;
        px = 24'hFFFFFF;
        for (int p = 0; p < npix; p++)
            for (int b = 23; b >= 0; b--)
                c = (c[15] ^ px[b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_h_total", ht0, 0);
        chk("rst_locked", lk0, 0);
        chk("rst_frame_done", fd0, 0);
        chk("rst_sig_lost", sl0, 0);
        rst = 1'b0;
        idle(5);

        // timing A: 40/32 pixels, 12/8 lines, five frames
        for (int f = 0; f < 5; f++) send_frame(40, 32, 8, 0, 12, -1, -1);
        #2;
        chk("a_fd_count", fd_n[0], 4);
        chk("a_h_total", cap_ht[0][3], 40);
        chk("a_h_active", cap_ha[0][3], 32);
        chk("a_v_total", cap_vt[0][3], 12);
        chk("a_v_active", cap_va[0][3], 8);
        chk("a_lock_fd1", cap_lk[0][0], 0);
        chk("a_lock_fd2", cap_lk[0][1], 0);
        chk("a_lock_fd3", cap_lk[0][2], 1);
        chk("a_hi_fd_count", fd_n[1], 4);
        chk("a_hi_h_total", cap_ht[1][3], 40);
        chk("a_hi_v_active", cap_va[1][3], 8);
        chk("a_hi_lock_fd3", cap_lk[1][2], 1);

        // frame 6 has one 41-cycle line, then four good frames
        send_frame(40, 32, 8, 0, 12, 5, -1);
        for (int f = 0; f < 4; f++) send_frame(40, 32, 8, 0, 12, -1, -1);
        #2;
        chk("long_fd_count", fd_n[0], 9);
        chk("long_lock_fd5", cap_lk[0][4], 1);
        chk("long_lock_fd6", cap_lk[0][5], 0);
        chk("long_lock_fd7", cap_lk[0][6], 0);
        chk("long_lock_fd8", cap_lk[0][7], 0);
        chk("long_lock_fd9", cap_lk[0][8], 1);
        chk("long_h_total_fd6", cap_ht[0][5], 40);

        // HS loss
        idle(3900);
        #2;
        chk("pre_lost_sig", sl0, 0);
        chk("pre_lost_locked", lk0, 1);
        idle(300);
        #2;
        chk("lost_sig", sl0, 1);
        chk("lost_locked", lk0, 0);
        chk("lost_h_total", ht0, 0);
        chk("lost_v_active", va0, 0);
        chk("lost_sig_hi", sl1, 1);
        n0 = fd_n[0];
        send_frame(40, 32, 8, 0, 4, -1, -1);
        #2;
        chk("restore_sig", sl0, 0);
        chk("restore_no_fd", fd_n[0], n0);
        send_frame(40, 32, 8, 4, 12, -1, -1);
        send_frame(40, 32, 8, 0, 3, -1, -1);
        #2;
        chk("restore_fd_count", fd_n[0], n0 + 1);
        chk("restore_v_total", cap_vt[0][n0], 12);
        chk("restore_h_active", cap_ha[0][n0], 32);

        // asynchronous reset mid-frame, off the clock edge
        #3 rst = 1'b1;
        #1;
        chk("async_rst_h_total", ht0, 0);
        chk("async_rst_v_total", vt0, 0);
        chk("async_rst_h_total_hi", ht1, 0);
        #3 rst = 1'b0;
        n0 = fd_n[0];
        send_frame(40, 32, 8, 3, 12, -1, -1);
        send_frame(40, 32, 8, 0, 12, -1, -1);
        #2;
        chk("post_rst_no_fd", fd_n[0], n0);
        send_frame(40, 32, 8, 0, 3, -1, -1);
        #2;
        chk("post_rst_fd_count", fd_n[0], n0 + 1);
        chk("post_rst_v_total", cap_vt[0][n0], 12);
        chk("post_rst_v_active", cap_va[0][n0], 8);

        // timing B: 52/40 pixels, 14/10 lines
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(5);
        n0 = fd_n[0];
        n1 = fd_n[1];
        for (int f = 0; f < 5; f++) send_frame(52, 40, 10, 0, 14, -1, -1);
        #2;
        chk("b_hi_fd_count", fd_n[1], n1 + 4);
        chk("b_hi_h_total", cap_ht[1][n1 + 3], 52);
        chk("b_hi_h_active", cap_ha[1][n1 + 3], 40);
        chk("b_hi_v_total", cap_vt[1][n1 + 3], 14);
        chk("b_hi_v_active", cap_va[1][n1 + 3], 10);
        chk("b_hi_lock_fd2", cap_lk[1][n1 + 1], 0);
        chk("b_hi_lock_fd3", cap_lk[1][n1 + 2], 1);
        chk("b_lo_h_total", cap_ht[0][n0 + 3], 52);

`ifdef VIDEO_CRC_EN
        crc_exp = crc_model(400);
        chk("crc_fd3", cap_crc[n0 + 2], crc_exp);
        chk("crc_fd4", cap_crc[n0 + 3], crc_exp);
        send_frame(52, 40, 10, 0, 14, -1, 3);
        send_frame(52, 40, 10, 0, 3, -1, -1);
        #2;
        chk("crc_bad_differs", cap_crc[n0 + 4] != crc_exp, 1);
        chk("crc_bad_lock_drop", cap_lk[0][n0 + 4], 0);
`else
        crc_exp = 16'h0000;
        chk("no_crc_port", crc0, crc_exp);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_meas.md
Name: vga_timing_meas

Overview:
- Sink-side counterpart of the pattern/VGA output path.
- Watches an incoming sync/DE/RGB stream, one pixel per CLK, and measures the video timing: horizontal total and active pixels, vertical total and active lines.
- Asserts LOCKED once the timing has been stable for a set number of frames.
- Used on loopback and capture boards to check generator output and to qualify external sources before a frame buffer writes.

Parameters:
- CW, 12, width of all measurement counters/outputs; counters saturate at 2^CW-1.
- HS_ACT, 0, active level of VGA_HS (0 = active-low sync).
- VS_ACT, 0, active level of VGA_VS.
- LOCK_FRAMES, 3, consecutive identical frames required before LOCKED=1 (range 1..15).

Ports:
- CLK  in  1  pixel clock; all inputs synchronous to it.
- RST  in  1  asynchronous, active-high reset.
- VGA_R  in  8  red pixel data.
- VGA_G  in  8  green pixel data.
- VGA_B  in  8  blue pixel data.
- VGA_HS  in  1  horizontal sync.
- VGA_VS  in  1  vertical sync.
- VGA_DE  in  1  data enable (active pixel).
- H_TOTAL  out  CW  cycles per line, last measured frame.
- H_ACTIVE  out  CW  DE-high cycles per line.
- V_TOTAL  out  CW  lines per frame.
- V_ACTIVE  out  CW  lines containing at least one DE cycle.
- FRAME_DONE  out  1  one-cycle pulse when outputs update.
- LOCKED  out  1  timing stable.
- SIG_LOST  out  1  no HS leading edge for 2^CW-1 cycles.

Behaviour:
- Reset: all outputs 0; all internal counters, previous-frame registers and the stable counter cleared.
- Input stage: all inputs registered once. Edge detectors work on the registered copy plus a one-cycle delayed copy.
- HS leading edge (transition into HS_ACT) marks line start, HSE.
- VS leading edge (transition into VS_ACT) marks frame start, VSE.
- h_cnt increments every cycle, saturating.
  - On HSE: line_total = h_cnt+1, then h_cnt = 0.
  - The first HSE after reset or SIG_LOST only starts counting and yields no line measurement.
- de_cnt counts registered DE=1 cycles in the line.
  - On HSE: line_active = de_cnt, then de_cnt = 0.
  - DE high in the same cycle as HSE counts toward the new line.
- Per frame:
  - First measured line of the frame sets frame H_TOTAL/H_ACTIVE.
  - Any later line with a different line_total sets frame_bad. Lines with line_active=0 are blanking: only their total is checked.
  - Differing nonzero line_active also sets frame_bad.
  - v_cnt increments on each HSE; va_cnt increments on each HSE whose line_active != 0. Both saturate.
- On VSE:
  - The VSE cycle's own HSE, if coincident, is counted in the ending frame first.
  - Then latch H_TOTAL/H_ACTIVE/V_TOTAL/V_ACTIVE from the completed frame and pulse FRAME_DONE one cycle later (latency VSE + 1 registered cycle, i.e. 2 CLK after the VS pin edge).
  - Then clear v_cnt, va_cnt and frame_bad.
  - The first VSE after reset or SIG_LOST latches nothing and produces no FRAME_DONE, since the frame is partial.
- Lock state machine:
  - States: SEARCH, COUNT, LOCK.
  - SEARCH: at a good VSE (frame_bad=0) store the measurement as reference and go to COUNT with stable=1.
  - COUNT: at a good VSE whose measurement equals the reference, stable++. At stable==LOCK_FRAMES go to LOCK and set LOCKED=1 in the same cycle as FRAME_DONE. LOCK_FRAMES=1 locks at the first good compare.
  - Any VSE with a mismatch or frame_bad: reload the reference from this frame if frame_bad=0, stable=1, state COUNT, LOCKED=0. If frame_bad=1, go to SEARCH.
  - LOCK: same compare at each VSE. A mismatch or bad frame drops LOCKED immediately, at that FRAME_DONE.
- SIG_LOST:
  - Set when h_cnt saturates.
  - Forces SEARCH, LOCKED=0, and clears the measurement outputs to 0.
  - Clears at the next HSE.
- VS absent: outputs hold and LOCKED holds; only HS loss is detected.

Optional Feature:
- VIDEO_CRC_EN
- Defined:
  - Adds output FRAME_CRC [15:0].
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over {R,G,B}, 24 bits per pixel, for every registered DE=1 cycle of the frame.
  - Latched with FRAME_DONE, reset to 0.
  - The running CRC reinitialises at VSE.
  - Equal CRC is an additional lock-compare term.
- Undefined: no port, no CRC logic; lock compares timing only.

Test Plan:
- 640x480@60 stream (800 total / 640 DE, 525 lines / 480 active, HS/VS active-low), 5 frames -> FRAME_DONE at frames 2..5 with 800/640/525/480; LOCKED=1 at the third FRAME_DONE (LOCK_FRAMES=3).
- While locked, one line of frame 6 lengthened to 801 cycles -> that FRAME_DONE shows LOCKED=0 and state returns to SEARCH; relock after 3 further good FRAME_DONEs.
- HS held inactive for 4095 cycles -> SIG_LOST=1, LOCKED=0, all measurements 0. HS restored -> SIG_LOST=0 at the first HSE, and no FRAME_DONE at the next VSE.
- RST pulsed mid-frame, asynchronously and not clock-aligned -> outputs 0 immediately; the first FRAME_DONE comes only after a full frame bounded by two VSEs.
- HS_ACT=1, VS_ACT=1, 800x600 timing (1056/800, 628/600) -> correct values, LOCKED after 3 frames.
- VIDEO_CRC_EN: constant pixel 0xFFFFFF over 640x480 -> FRAME_CRC matches the bench CRC model and is identical every frame. Changing one pixel -> CRC differs and LOCKED drops.
